// File: rtl/sram_1rw_init_ext.sv
// rtl/sram_1rw_init_ext.sv - parametrised 1RW SRAM with post-reset zero-init, read-valid and optional output stage
// Define SRAM_PARITY_EN to store one even-parity bit per GRAN lane and flag mismatches on RW0_perr.
module sram_1rw_init_ext #(
  parameter  int DATA_WIDTH = 256,
  parameter  int DEPTH      = 512,
  parameter  int GRAN       = 8,
  parameter  int OUT_REG    = 0,
  localparam int AW         = $clog2(DEPTH),
  localparam int MW         = DATA_WIDTH / GRAN
) (
  input  logic                  RW0_clk,
  input  logic                  RW0_rst,
  output logic                  RW0_ready,
  input  logic                  RW0_en,
  input  logic                  RW0_wmode,
  input  logic [AW-1:0]         RW0_addr,
  input  logic [MW-1:0]         RW0_wmask,
  input  logic [DATA_WIDTH-1:0] RW0_wdata,
  input  logic                  RW0_inj,
  output logic                  RW0_rvalid,
  output logic [DATA_WIDTH-1:0] RW0_rdata,
  output logic                  RW0_perr
);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          init_we;

  logic ready;
  logic acc;
  logic acc_wr;
  logic acc_rd;
  logic in_range;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_perr;

  logic                  s1_valid;
  logic                  s1_perr;
  logic [DATA_WIDTH-1:0] s1_data;

  // Init FSM: sweeps every word to zero once after reset, then stays READY.
  always_ff @(posedge RW0_clk) begin
    if (RW0_rst) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    init_we = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        ptr_d   = ptr_q + 1'b1;
        if (ptr_q == LAST_ADDR) begin
          state_d = ST_READY;
          ptr_d   = '0;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = '0;
      end
    endcase
  end

  assign ready     = (state_q == ST_READY);
  assign RW0_ready = ready;

  // A request sampled together with reset is dropped, like an in-flight read.
  assign acc      = RW0_en & ready & ~RW0_rst;
  assign acc_wr   = acc & RW0_wmode;
  assign acc_rd   = acc & ~RW0_wmode;
  assign in_range = ({1'b0, RW0_addr} < DEPTH_EXT);

  always_ff @(posedge RW0_clk) begin
    if (init_we && !RW0_rst) begin
      mem[ptr_q] <= '0;
    end else if (acc_wr && in_range) begin
      for (int i = 0; i < MW; i++) begin
        if (RW0_wmask[i]) begin
          mem[RW0_addr][i*GRAN +: GRAN] <= RW0_wdata[i*GRAN +: GRAN];
        end
      end
    end
  end

  assign rd_word = in_range ? mem[RW0_addr] : '0;

`ifdef SRAM_PARITY_EN
  logic [MW-1:0] par_mem [DEPTH];
  logic [MW-1:0] wr_par;
  logic [MW-1:0] rd_par;
  logic [MW-1:0] par_stored;

  // Injection flips the stored parity of every lane written in that request.
  always_comb begin
    wr_par = '0;
    rd_par = '0;
    for (int i = 0; i < MW; i++) begin
      wr_par[i] = (^RW0_wdata[i*GRAN +: GRAN]) ^ RW0_inj;
      rd_par[i] = ^rd_word[i*GRAN +: GRAN];
    end
  end

  always_ff @(posedge RW0_clk) begin
    if (init_we && !RW0_rst) begin
      par_mem[ptr_q] <= '0;
    end else if (acc_wr && in_range) begin
      for (int i = 0; i < MW; i++) begin
        if (RW0_wmask[i]) begin
          par_mem[RW0_addr][i] <= wr_par[i];
        end
      end
    end
  end

  assign par_stored = in_range ? par_mem[RW0_addr] : '0;
  assign rd_perr    = |(par_stored ^ rd_par);
`else
  logic unused_inj;
  assign unused_inj = RW0_inj;
  assign rd_perr    = 1'b0;
`endif

  // Stage 1: array read; data only moves on a read so the output holds between reads.
  always_ff @(posedge RW0_clk) begin
    if (RW0_rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_perr  <= 1'b0;
    end else begin
      s1_valid <= acc_rd;
      if (acc_rd) begin
        s1_data <= rd_word;
        s1_perr <= rd_perr;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic                  s2_valid;
      logic                  s2_perr;
      logic [DATA_WIDTH-1:0] s2_data;

      always_ff @(posedge RW0_clk) begin
        if (RW0_rst) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
          s2_perr  <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
            s2_perr <= s1_perr;
          end
        end
      end

      assign RW0_rvalid = s2_valid;
      assign RW0_rdata  = s2_data;
      assign RW0_perr   = s2_valid & s2_perr;
    end else begin : g_noreg
      assign RW0_rvalid = s1_valid;
      assign RW0_rdata  = s1_data;
      assign RW0_perr   = s1_valid & s1_perr;
    end
  endgenerate

endmodule

// File: tb/tb_sram_1rw_init_ext.sv
// tb/tb_sram_1rw_init_ext.sv - checks a DEPTH=16/OUT_REG=0 and a DEPTH=12/OUT_REG=1 instance against a word-level model
module tb_sram_1rw_init_ext;

  localparam int DW      = 64;
  localparam int GR      = 8;
  localparam int MW      = DW / GR;
  localparam int AW      = 4;
  localparam int DEPTH_A = 16;
  localparam int DEPTH_B = 12;
`ifdef SRAM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, wmode, inj;
  logic [AW-1:0] addr;
  logic [MW-1:0] wmask;
  logic [DW-1:0] wdata;

  logic          ready_a, rvalid_a, perr_a;
  logic [DW-1:0] rdata_a;
  logic          ready_b, rvalid_b, perr_b;
  logic [DW-1:0] rdata_b;

  sram_1rw_init_ext #(.DATA_WIDTH(DW), .DEPTH(DEPTH_A), .GRAN(GR), .OUT_REG(0)) dut_a (
    .RW0_clk(clk), .RW0_rst(rst), .RW0_ready(ready_a), .RW0_en(en), .RW0_wmode(wmode),
    .RW0_addr(addr), .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_inj(inj),
    .RW0_rvalid(rvalid_a), .RW0_rdata(rdata_a), .RW0_perr(perr_a)
  );

  sram_1rw_init_ext #(.DATA_WIDTH(DW), .DEPTH(DEPTH_B), .GRAN(GR), .OUT_REG(1)) dut_b (
    .RW0_clk(clk), .RW0_rst(rst), .RW0_ready(ready_b), .RW0_en(en), .RW0_wmode(wmode),
    .RW0_addr(addr), .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_inj(inj),
    .RW0_rvalid(rvalid_b), .RW0_rdata(rdata_b), .RW0_perr(perr_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: word array per instance, init counter, and a time wheel of due read results.
  logic [DW-1:0] m_mem  [2][16];
  logic [MW-1:0] m_flip [2][16];
  int            m_cnt  [2];
  bit            w_v    [2][4];
  logic [DW-1:0] w_d    [2][4];
  bit            w_p    [2][4];
  logic [DW-1:0] m_hold [2];

  logic [DW-1:0] last_data [2];
  logic          last_perr [2];
  int            rv_cnt    [2];

  logic          c_r, c_v, c_p, e_v, e_p;
  logic [DW-1:0] c_d;
  int            slot;

  function automatic int dep(input int i);
    return (i == 0) ? DEPTH_A : DEPTH_B;
  endfunction

  function automatic int lat(input int i);
    return (i == 0) ? 0 : 1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_step(input int i);
    int s;
    if (rst) begin
      m_cnt[i]  = 0;
      m_hold[i] = '0;
      for (int k = 0; k < 4; k++) w_v[i][k] = 1'b0;
      for (int a = 0; a < 16; a++) begin
        m_mem[i][a]  = '0;
        m_flip[i][a] = '0;
      end
    end else begin
      if (m_cnt[i] >= dep(i) && en) begin
        if (wmode) begin
          if (addr < dep(i)) begin
            for (int l = 0; l < MW; l++) begin
              if (wmask[l]) begin
                m_mem[i][addr][l*GR +: GR] = wdata[l*GR +: GR];
                m_flip[i][addr][l]         = inj;
              end
            end
          end
        end else begin
          s         = (cyc + lat(i)) % 4;
          w_v[i][s] = 1'b1;
          w_d[i][s] = (addr < dep(i)) ? m_mem[i][addr] : '0;
          w_p[i][s] = PAR && (addr < dep(i)) && (|m_flip[i][addr]);
        end
      end
      if (m_cnt[i] < dep(i)) m_cnt[i]++;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step(0);
    model_step(1);
    #1;
    for (int i = 0; i < 2; i++) begin
      c_r  = (i == 0) ? ready_a  : ready_b;
      c_v  = (i == 0) ? rvalid_a : rvalid_b;
      c_d  = (i == 0) ? rdata_a  : rdata_b;
      c_p  = (i == 0) ? perr_a   : perr_b;
      slot = cyc % 4;
      e_v  = w_v[i][slot];
      e_p  = 1'b0;
      if (e_v) begin
        m_hold[i]    = w_d[i][slot];
        e_p          = w_p[i][slot];
        w_v[i][slot] = 1'b0;
      end
      chk(i == 0 ? "a.ready"  : "b.ready",  c_r, m_cnt[i] >= dep(i));
      chk(i == 0 ? "a.rvalid" : "b.rvalid", c_v, e_v);
      chk(i == 0 ? "a.rdata"  : "b.rdata",  c_d, m_hold[i]);
      chk(i == 0 ? "a.perr"   : "b.perr",   c_p, e_p);
      if (c_v === 1'b1) begin
        last_data[i] = c_d;
        last_perr[i] = c_p;
        rv_cnt[i]++;
      end
    end
  end

  task automatic req(input logic w, input logic [AW-1:0] a, input logic [MW-1:0] m,
                     input logic [DW-1:0] d, input logic j);
    en = 1'b1; wmode = w; addr = a; wmask = m; wdata = d; inj = j;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called on the negedge where reset was released; optionally writes during INIT.
  task automatic init_watch(input bit wr_during_init);
    chk("init.start.a", ready_a, 1'b0);
    chk("init.start.b", ready_b, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      if (wr_during_init && i == 2) begin
        en = 1'b1; wmode = 1'b1; addr = 4'd3; wmask = 8'hFF; wdata = 64'hFFFF_FFFF_FFFF_FFFF; inj = 1'b0;
      end else begin
        en = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("init.ready_a", ready_a, i == 16);
      chk("init.ready_b", ready_b, i >= 12);
      @(negedge clk);
    end
    en = 1'b0;
  endtask

  int n_a, n_b;

  initial begin
    rst = 1'b1; en = 1'b0; wmode = 1'b0; inj = 1'b0;
    addr = '0; wmask = '0; wdata = '0;
    for (int i = 0; i < 2; i++) begin
      last_data[i] = '0; last_perr[i] = 1'b0; rv_cnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("reset.rdata_a", rdata_a, 64'h0);
    chk("reset.rvalid_b", rvalid_b, 1'b0);
    rst = 1'b0;
    init_watch(1'b1);

    // Write during INIT must not land: word 3 reads zero.
    req(1'b0, 4'd3, 8'h00, 64'h0, 1'b0);
    idle(3);
    chk("init_wr_dropped.a", last_data[0], 64'h0);
    chk("init_wr_dropped.b", last_data[1], 64'h0);
    chk("rd3.count.a", rv_cnt[0], 1);

    req(1'b1, 4'd5, 8'hFF, 64'h1122_3344_5566_7788, 1'b0);
    req(1'b1, 4'd5, 8'h0F, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
    req(1'b0, 4'd5, 8'h00, 64'h0, 1'b0);
    idle(3);
    chk("mask.a", last_data[0], 64'h1122_3344_AAAA_AAAA);
    chk("mask.b", last_data[1], 64'h1122_3344_AAAA_AAAA);
    chk("model.word5", m_mem[0][5], 64'h1122_3344_AAAA_AAAA);

    req(1'b1, 4'd5, 8'h00, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    req(1'b0, 4'd5, 8'h00, 64'h0, 1'b0);
    idle(3);
    chk("mask0.a", last_data[0], 64'h1122_3344_AAAA_AAAA);

    req(1'b1, 4'd0, 8'hFF, 64'hA0, 1'b0);
    req(1'b1, 4'd1, 8'hFF, 64'hA1, 1'b0);
    req(1'b1, 4'd2, 8'hFF, 64'hA2, 1'b0);
    for (int k = 0; k <= 4; k++) begin
      if (k < 3) begin
        en = 1'b1; wmode = 1'b0; addr = AW'(k);
      end else begin
        en = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("pipe.rvalid_a", rvalid_a, k <= 2);
      if (k <= 2) chk("pipe.rdata_a", rdata_a, 64'hA0 + 64'(k));
      chk("pipe.rvalid_b", rvalid_b, k >= 1 && k <= 3);
      if (k >= 1 && k <= 3) chk("pipe.rdata_b", rdata_b, 64'hA0 + 64'(k - 1));
      @(negedge clk);
    end
    en = 1'b0;

    // Address 13 exists in A only.
    req(1'b1, 4'd13, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0);
    req(1'b0, 4'd13, 8'h00, 64'h0, 1'b0);
    idle(3);
    chk("oor.a", last_data[0], 64'h0123_4567_89AB_CDEF);
    chk("oor.b", last_data[1], 64'h0);

    req(1'b1, 4'd2, 8'h01, 64'h55, 1'b1);
    req(1'b0, 4'd2, 8'h00, 64'h0, 1'b0);
    idle(3);
    chk("par.inj.a", last_perr[0], PAR);
    chk("par.inj.b", last_perr[1], PAR);
    chk("par.data.a", last_data[0], 64'h55);
    req(1'b1, 4'd2, 8'h01, 64'h55, 1'b0);
    req(1'b0, 4'd2, 8'h00, 64'h0, 1'b0);
    idle(3);
    chk("par.clean.a", last_perr[0], 1'b0);
    chk("par.clean.b", last_perr[1], 1'b0);

    // Reset one cycle after a read: A already answered, B's answer is dropped.
    n_a = rv_cnt[0];
    n_b = rv_cnt[1];
    req(1'b0, 4'd1, 8'h00, 64'h0, 1'b0);
    en = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1; wmode = 1'b0; addr = 4'd1;
    repeat (7) @(negedge clk);
    en = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    init_watch(1'b0);
    chk("drop.count_a", rv_cnt[0], n_a + 1);
    chk("drop.count_b", rv_cnt[1], n_b);

    req(1'b0, 4'd5, 8'h00, 64'h0, 1'b0);
    idle(3);
    chk("reinit.a", last_data[0], 64'h0);
    chk("reinit.b", last_data[1], 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
